minmax_tracker: RTL

- Streaming windowed comparator with a runtime signed/unsigned mode.
- Accepts one sample per handshake. Over each window of WIN_LEN accepted samples, tracks the running maximum and minimum and the in-window index of each.
- Presents the window result on an output handshake.
- Sits after the sample datapath and feeds peak/level reporting logic.

---
 rtl/minmax_tracker.sv | 107 ++++++++++
 1 files changed

// File: rtl/minmax_tracker.sv
// Windowed max/min tracker with per-window signed/unsigned compare.
// Reports extremes and their earliest in-window indices on a handshake.
module minmax_tracker #(
  parameter int WIDTH   = 8,
  parameter int WIN_LEN = 16,
  parameter int IDX_W   = $clog2(WIN_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_max,
  output logic [WIDTH-1:0] m_min,
  output logic [IDX_W-1:0] m_max_idx,
  output logic [IDX_W-1:0] m_min_idx
);

  typedef enum logic [1:0] {
    FIRST,
    ACC,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(WIN_LEN - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] count_q;
  logic             mode_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_q;
  logic [IDX_W-1:0] max_idx_q;
  logic [IDX_W-1:0] min_idx_q;
  logic             accept;
  logic             last;

  // Flipping the MSB maps two's complement onto unsigned order.
  function automatic logic gt(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sgn
  );
    logic [WIDTH-1:0] ka;
    logic [WIDTH-1:0] kb;
    ka = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
    kb = {b[WIDTH-1] ^ sgn, b[WIDTH-2:0]};
    return ka > kb;
  endfunction

  assign s_ready   = (state_q != DONE);
  assign m_valid   = (state_q == DONE);
  assign accept    = s_valid && s_ready;
  assign last      = (count_q == LAST);
  assign m_max     = max_q;
  assign m_min     = min_q;
  assign m_max_idx = max_idx_q;
  assign m_min_idx = min_idx_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FIRST: if (accept) state_d = ACC;
      ACC: if (accept && last) state_d = DONE;
      DONE: if (m_ready) state_d = FIRST;
      default: state_d = FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FIRST;
      count_q   <= '0;
      mode_q    <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == FIRST) begin
        max_q     <= s_data;
        min_q     <= s_data;
        max_idx_q <= '0;
        min_idx_q <= '0;
        mode_q    <= mode;
        count_q   <= IDX_W'(1);
      end else if (accept) begin
        if (gt(s_data, max_q, mode_q)) begin
          max_q     <= s_data;
          max_idx_q <= count_q;
        end
        if (gt(min_q, s_data, mode_q)) begin
          min_q     <= s_data;
          min_idx_q <= count_q;
        end
        count_q <= last ? '0
                        : count_q + IDX_W'(1);
      end
    end
  end

endmodule
